datapath_unit: RTL and testbench
================================

Name: datapath_unit

Overview:
- 32-bit single-bus processor datapath.
- Contains 16 general registers, HI/LO, PC, IR, MAR, MDR, Y, a 64-bit Z register and a 5-bit-opcode ALU.
- An external control unit or bench drives a 32-bit enable word, ALU select and memory strobes every cycle.
- All storage contents are exported for observation.

Parameters:
- WIDTH, 32, datapath word width; Z is 2*WIDTH.

Ports:
- Clock  in  1  single system clock; all registers update on its rising edge.
- clr  in  1  asynchronous, active-high reset.
- i  in  32  control word: register-load enables, bus-source select and IncPC (map in Behaviour).
- ALU_Sel  in  5  ALU operation code.
- Mdatain  in  32  memory read data.
- Read  in  1  selects Mdatain (1) or the bus (0) as the MDR input.
- bus_contents  out  32  current bus value.
- MDR_data_out  out  32  MDR contents.
- r0_data_out..r15_data_out  out  32 each  general register contents.
- HI_data_out, LO_data_out  out  32 each  HI and LO contents.
- Zhigh_data_out, Zlow_data_out  out  32 each  upper and lower halves of Z.
- PC_data_out, IR_data_out, MAR_data_out, Y_data_out  out  32 each  PC, IR, MAR and Y contents.

Behaviour:
- Control word map:
  - i[15:0]: R0in..R15in.
  - i[16] HIin, i[17] LOin, i[18] Zhighin, i[19] Zlowin.
  - i[20] PCin, i[21] IRin, i[22] MDRin, i[23] MARin, i[24] Yin.
  - i[29:25]: bus source code. 0 MDR, 1..16 R0..R15, 17 HI, 18 LO, 19 Zhigh, 20 Zlow, 21 PC, 22 IR, 23..31 drive 0.
  - i[30]: IncPC.
  - i[31]: reserved, ignored.
- Bus: purely combinational mux selected by i[29:25]; bus_contents equals the selected value in the same cycle.
- Register loads:
  - Every register loads bus_contents on the rising edge of Clock when its enable is 1; otherwise it holds.
  - R0 is an ordinary register.
- MDR: when MDRin=1, loads Mdatain if Read=1, else bus_contents. Read alone, without MDRin, has no effect.
- PC:
  - IncPC=1 → PC <= PC+1, wrapping from 0xFFFFFFFF to 0.
  - IncPC has priority over PCin when both are asserted.
- ALU:
  - Combinational; A = Y, B = bus_contents, 64-bit result C.
  - Opcodes: 0 ADD, 1 SUB (A-B), 2 OR, 3 AND, 4 SHR (logical), 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 MUL (signed 32x32→64), 10 DIV (signed), 11 NEG (-B), 12 NOT (~B).
  - Opcodes 13..31: C = 0.
  - Shift and rotate amount is B[4:0].
  - For all non-MUL/DIV operations, C[63:32]=0 and C[31:0] is the 32-bit result. Add/sub wrap modulo 2^32.
  - DIV: C[31:0]=quotient (truncated toward zero), C[63:32]=remainder.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = A.
- Z register: Zhigh <= C[63:32] when Zhighin=1; Zlow <= C[31:0] when Zlowin=1. The halves are independent.
- Simultaneous loads: any number of destinations may load the same bus value in one cycle.
- A register that is both the bus source and the destination loads its own value (no change).
- Reset: clr=1 asynchronously clears every register (R0..R15, HI, LO, Z, PC, IR, MAR, MDR, Y) to 0 and holds them there while asserted. Reset wins over all enables, including mid-operation.
- Latency:
  - Load enable to visible *_data_out: 1 clock edge.
  - Bus and ALU result to the Z input: same cycle, combinational.

Decomposition:
- Shared package holds:
  - ALU opcode constants (ALU_ADD..ALU_NOT).
  - Bus source codes.
  - Control-word bit index constants (IDX_R0IN..IDX_INCPC).
- One natural sub-module: alu_unit (Y, bus, ALU_Sel → 64-bit C).
- Registers are implemented inline.

Test Plan:
- Register load: Mdatain=0x22, Read=1, MDRin=1 for one edge, then bus code 0 with R2in=1 → MDR=0x22 and r2_data_out=0x22. Repeat 0x24→R4 and 0x26→R5.
- AND sequence:
  - Bus=R2 (code 3), Yin → Y=0x22.
  - Bus=R4 (code 5), ALU_Sel=3, Zlowin → Zlow=0x20, Zhigh unchanged.
  - Bus=Zlow (code 20), R5in → R5=0x20.
- Fetch: MARin with bus=PC and IncPC → MAR=0, PC=1. Then Mdatain=0x4A920000, Read, MDRin; then IRin from MDR → IR=0x4A920000.
- MUL/DIV:
  - Y=0x00010000, B=0x00010000, op 9, Zhighin+Zlowin → Zhigh=1, Zlow=0.
  - Y=-7, B=2, op 10 → Zlow=0xFFFFFFFD, Zhigh=0xFFFFFFFF.
  - B=0 → Zlow=0xFFFFFFFF, Zhigh=A.
- Shifts: Y=0x80000001, B=1 → SHR 0x40000000, SHRA 0xC0000000, ROR 0xC0000000, ROL 0x00000003, SHL 0x00000002.
- Reset: assert clr between clock edges while R5in=1 and registers are nonzero → all outputs 0 immediately and through the next edge. After release, loads resume normally.

Source files
------------

// File: rtl/datapath_unit_pkg.sv
// Shared constants for the single-bus datapath: control-word bit positions,
// bus source codes and ALU opcodes.
package datapath_unit_pkg;

    typedef logic [4:0] alu_op_t;
    typedef logic [4:0] bus_src_t;

    localparam int IDX_R0IN    = 0;
    localparam int IDX_HIIN    = 16;
    localparam int IDX_LOIN    = 17;
    localparam int IDX_ZHIGHIN = 18;
    localparam int IDX_ZLOWIN  = 19;
    localparam int IDX_PCIN    = 20;
    localparam int IDX_IRIN    = 21;
    localparam int IDX_MDRIN   = 22;
    localparam int IDX_MARIN   = 23;
    localparam int IDX_YIN     = 24;
    localparam int IDX_BUS_LO  = 25;
    localparam int IDX_BUS_HI  = 29;
    localparam int IDX_INCPC   = 30;

    localparam bus_src_t BUS_MDR   = 5'd0;
    localparam bus_src_t BUS_R0    = 5'd1;
    localparam bus_src_t BUS_R15   = 5'd16;
    localparam bus_src_t BUS_HI    = 5'd17;
    localparam bus_src_t BUS_LO    = 5'd18;
    localparam bus_src_t BUS_ZHIGH = 5'd19;
    localparam bus_src_t BUS_ZLOW  = 5'd20;
    localparam bus_src_t BUS_PC    = 5'd21;
    localparam bus_src_t BUS_IR    = 5'd22;

    localparam alu_op_t ALU_ADD  = 5'd0;
    localparam alu_op_t ALU_SUB  = 5'd1;
    localparam alu_op_t ALU_OR   = 5'd2;
    localparam alu_op_t ALU_AND  = 5'd3;
    localparam alu_op_t ALU_SHR  = 5'd4;
    localparam alu_op_t ALU_SHRA = 5'd5;
    localparam alu_op_t ALU_SHL  = 5'd6;
    localparam alu_op_t ALU_ROR  = 5'd7;
    localparam alu_op_t ALU_ROL  = 5'd8;
    localparam alu_op_t ALU_MUL  = 5'd9;
    localparam alu_op_t ALU_DIV  = 5'd10;
    localparam alu_op_t ALU_NEG  = 5'd11;
    localparam alu_op_t ALU_NOT  = 5'd12;

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU: A comes from Y, B from the bus, 2*WIDTH-bit result C.
// Single-word results leave the upper half of C at zero.
module alu_unit
    import datapath_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [4:0]         alu_sel,
    output logic [2*WIDTH-1:0] c
);

    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0]          amt;
    logic [2*WIDTH-1:0]     dbl;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_safe;
    logic signed [WIDTH-1:0] quo;
    logic signed [WIDTH-1:0] rem;

    assign amt  = b[SW-1:0];
    assign a_s  = $signed(a);
    assign prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

    // The divider never sees zero; the divide-by-zero result is patched in below.
    assign b_safe = (b == '0) ? WIDTH'(1) : $signed(b);
    assign quo    = a_s / b_safe;
    assign rem    = a_s % b_safe;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        c   = '0;
        dbl = '0;
        case (alu_sel)
            ALU_ADD:  c[WIDTH-1:0] = a + b;
            ALU_SUB:  c[WIDTH-1:0] = a - b;
            ALU_OR:   c[WIDTH-1:0] = a | b;
            ALU_AND:  c[WIDTH-1:0] = a & b;
            ALU_SHR:  c[WIDTH-1:0] = a >> amt;
            ALU_SHRA: c[WIDTH-1:0] = a_s >>> amt;
            ALU_SHL:  c[WIDTH-1:0] = a << amt;
            ALU_ROR: begin
                dbl          = {a, a} >> amt;
                c[WIDTH-1:0] = dbl[WIDTH-1:0];
            end
            ALU_ROL: begin
                dbl          = {a, a} << amt;
                c[WIDTH-1:0] = dbl[2*WIDTH-1:WIDTH];
            end
            ALU_MUL:  c = prod;
            ALU_DIV: begin
                if (b == '0) c = {a, {WIDTH{1'b1}}};
                else         c = {rem, quo};
            end
            ALU_NEG:  c[WIDTH-1:0] = -b;
            ALU_NOT:  c[WIDTH-1:0] = ~b;
            default:  c = '0;
        endcase
    end

endmodule

// File: rtl/datapath_unit.sv
// Single-bus processor datapath: register set, bus source mux, ALU and Z.
// Every storage element loads the bus (or its dedicated input) on its enable.
module datapath_unit
    import datapath_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             clr,
    input  logic [31:0]      i,
    input  logic [4:0]       ALU_Sel,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             Read,
    output logic [WIDTH-1:0] bus_contents,
    output logic [WIDTH-1:0] MDR_data_out,
    output logic [WIDTH-1:0] r0_data_out,
    output logic [WIDTH-1:0] r1_data_out,
    output logic [WIDTH-1:0] r2_data_out,
    output logic [WIDTH-1:0] r3_data_out,
    output logic [WIDTH-1:0] r4_data_out,
    output logic [WIDTH-1:0] r5_data_out,
    output logic [WIDTH-1:0] r6_data_out,
    output logic [WIDTH-1:0] r7_data_out,
    output logic [WIDTH-1:0] r8_data_out,
    output logic [WIDTH-1:0] r9_data_out,
    output logic [WIDTH-1:0] r10_data_out,
    output logic [WIDTH-1:0] r11_data_out,
    output logic [WIDTH-1:0] r12_data_out,
    output logic [WIDTH-1:0] r13_data_out,
    output logic [WIDTH-1:0] r14_data_out,
    output logic [WIDTH-1:0] r15_data_out,
    output logic [WIDTH-1:0] HI_data_out,
    output logic [WIDTH-1:0] LO_data_out,
    output logic [WIDTH-1:0] Zhigh_data_out,
    output logic [WIDTH-1:0] Zlow_data_out,
    output logic [WIDTH-1:0] PC_data_out,
    output logic [WIDTH-1:0] IR_data_out,
    output logic [WIDTH-1:0] MAR_data_out,
    output logic [WIDTH-1:0] Y_data_out
);

    logic [WIDTH-1:0] r_q [16];
    logic [WIDTH-1:0] r_d [16];
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] zhigh_q, zhigh_d, zlow_q, zlow_d;
    logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d;
    logic [WIDTH-1:0] mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;

    logic [WIDTH-1:0]   bus;
    logic [2*WIDTH-1:0] alu_c;
    bus_src_t           bus_src;
    logic [3:0]         r_idx;
    logic               unused_reserved;

    assign bus_src         = i[IDX_BUS_HI:IDX_BUS_LO];
    assign r_idx           = 4'(bus_src - BUS_R0);
    assign unused_reserved = i[31];

    always_comb begin
        bus = '0;
        case (bus_src)
            BUS_MDR:   bus = mdr_q;
            BUS_HI:    bus = hi_q;
            BUS_LO:    bus = lo_q;
            BUS_ZHIGH: bus = zhigh_q;
            BUS_ZLOW:  bus = zlow_q;
            BUS_PC:    bus = pc_q;
            BUS_IR:    bus = ir_q;
            default: begin
                if (bus_src >= BUS_R0 && bus_src <= BUS_R15) bus = r_q[r_idx];
            end
        endcase
    end

    alu_unit #(.WIDTH(WIDTH)) u_alu (
        .a       (y_q),
        .b       (bus),
        .alu_sel (ALU_Sel),
        .c       (alu_c)
    );

    always_comb begin
        for (int k = 0; k < 16; k++) r_d[k] = i[IDX_R0IN + k] ? bus : r_q[k];
        hi_d    = i[IDX_HIIN]    ? bus : hi_q;
        lo_d    = i[IDX_LOIN]    ? bus : lo_q;
        zhigh_d = i[IDX_ZHIGHIN] ? alu_c[2*WIDTH-1:WIDTH] : zhigh_q;
        zlow_d  = i[IDX_ZLOWIN]  ? alu_c[WIDTH-1:0] : zlow_q;
        ir_d    = i[IDX_IRIN]    ? bus : ir_q;
        mar_d   = i[IDX_MARIN]   ? bus : mar_q;
        y_d     = i[IDX_YIN]     ? bus : y_q;
        mdr_d   = i[IDX_MDRIN]   ? (Read ? Mdatain : bus) : mdr_q;
        // Increment wins over a bus load into PC.
        if (i[IDX_INCPC])     pc_d = pc_q + WIDTH'(1);
        else if (i[IDX_PCIN]) pc_d = bus;
        else                  pc_d = pc_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or posedge clr) begin
        if (clr) begin
            // NOTE: the register file is reset explicitly because software observes it straight out of reset.
            for (int k = 0; k < 16; k++) r_q[k] <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            zhigh_q <= '0;
            zlow_q  <= '0;
            pc_q    <= '0;
            ir_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            y_q     <= '0;
        end else begin
            for (int k = 0; k < 16; k++) r_q[k] <= r_d[k];
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            zhigh_q <= zhigh_d;
            zlow_q  <= zlow_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            y_q     <= y_d;
        end
    end

    assign bus_contents   = bus;
    assign MDR_data_out   = mdr_q;
    assign r0_data_out    = r_q[0];
    assign r1_data_out    = r_q[1];
    assign r2_data_out    = r_q[2];
    assign r3_data_out    = r_q[3];
    assign r4_data_out    = r_q[4];
    assign r5_data_out    = r_q[5];
    assign r6_data_out    = r_q[6];
    assign r7_data_out    = r_q[7];
    assign r8_data_out    = r_q[8];
    assign r9_data_out    = r_q[9];
    assign r10_data_out   = r_q[10];
    assign r11_data_out   = r_q[11];
    assign r12_data_out   = r_q[12];
    assign r13_data_out   = r_q[13];
    assign r14_data_out   = r_q[14];
    assign r15_data_out   = r_q[15];
    assign HI_data_out    = hi_q;
    assign LO_data_out    = lo_q;
    assign Zhigh_data_out = zhigh_q;
    assign Zlow_data_out  = zlow_q;
    assign PC_data_out    = pc_q;
    assign IR_data_out    = ir_q;
    assign MAR_data_out   = mar_q;
    assign Y_data_out     = y_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed bench for datapath_unit: expectations are queued when a step is
// driven and compared against the observed output after the clock edge.
module tb_datapath_unit;

    logic        Clock;
    logic        clr;
    logic [31:0] i;
    logic [4:0]  ALU_Sel;
    logic [31:0] Mdatain;
    logic        Read;
    logic [31:0] bus_contents, MDR_data_out;
    logic [31:0] r0_data_out, r1_data_out, r2_data_out, r3_data_out;
    logic [31:0] r4_data_out, r5_data_out, r6_data_out, r7_data_out;
    logic [31:0] r8_data_out, r9_data_out, r10_data_out, r11_data_out;
    logic [31:0] r12_data_out, r13_data_out, r14_data_out, r15_data_out;
    logic [31:0] HI_data_out, LO_data_out, Zhigh_data_out, Zlow_data_out;
    logic [31:0] PC_data_out, IR_data_out, MAR_data_out, Y_data_out;

    datapath_unit dut (
        .Clock(Clock), .clr(clr), .i(i), .ALU_Sel(ALU_Sel), .Mdatain(Mdatain), .Read(Read),
        .bus_contents(bus_contents), .MDR_data_out(MDR_data_out),
        .r0_data_out(r0_data_out), .r1_data_out(r1_data_out), .r2_data_out(r2_data_out),
        .r3_data_out(r3_data_out), .r4_data_out(r4_data_out), .r5_data_out(r5_data_out),
        .r6_data_out(r6_data_out), .r7_data_out(r7_data_out), .r8_data_out(r8_data_out),
        .r9_data_out(r9_data_out), .r10_data_out(r10_data_out), .r11_data_out(r11_data_out),
        .r12_data_out(r12_data_out), .r13_data_out(r13_data_out), .r14_data_out(r14_data_out),
        .r15_data_out(r15_data_out), .HI_data_out(HI_data_out), .LO_data_out(LO_data_out),
        .Zhigh_data_out(Zhigh_data_out), .Zlow_data_out(Zlow_data_out),
        .PC_data_out(PC_data_out), .IR_data_out(IR_data_out),
        .MAR_data_out(MAR_data_out), .Y_data_out(Y_data_out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [31:0] EN_HI  = 32'h1 << 16;
    localparam logic [31:0] EN_LO  = 32'h1 << 17;
    localparam logic [31:0] EN_ZH  = 32'h1 << 18;
    localparam logic [31:0] EN_ZL  = 32'h1 << 19;
    localparam logic [31:0] EN_PC  = 32'h1 << 20;
    localparam logic [31:0] EN_IR  = 32'h1 << 21;
    localparam logic [31:0] EN_MDR = 32'h1 << 22;
    localparam logic [31:0] EN_MAR = 32'h1 << 23;
    localparam logic [31:0] EN_Y   = 32'h1 << 24;
    localparam logic [31:0] EN_INC = 32'h1 << 30;

    localparam int O_HI = 16, O_LO = 17, O_ZH = 18, O_ZL = 19, O_PC = 20;
    localparam int O_IR = 21, O_MAR = 22, O_MDR = 23, O_Y = 24, O_BUS = 25;

    typedef struct {
        string       tag;
        int          src;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] en_r(input int k);
        return 32'h1 << k;
    endfunction

    function automatic logic [31:0] cw(input logic [4:0] src, input logic [31:0] en);
        return en | ({27'd0, src} << 25);
    endfunction

    function automatic logic [31:0] obs(input int s);
        case (s)
            0: return r0_data_out;    1: return r1_data_out;
            2: return r2_data_out;    3: return r3_data_out;
            4: return r4_data_out;    5: return r5_data_out;
            6: return r6_data_out;    7: return r7_data_out;
            8: return r8_data_out;    9: return r9_data_out;
            10: return r10_data_out;  11: return r11_data_out;
            12: return r12_data_out;  13: return r13_data_out;
            14: return r14_data_out;  15: return r15_data_out;
            O_HI: return HI_data_out;  O_LO: return LO_data_out;
            O_ZH: return Zhigh_data_out; O_ZL: return Zlow_data_out;
            O_PC: return PC_data_out;  O_IR: return IR_data_out;
            O_MAR: return MAR_data_out; O_MDR: return MDR_data_out;
            O_Y: return Y_data_out;
            default: return bus_contents;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic expect_val(input string tag, input int src, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.src), e.val);
        end
    endtask

    task automatic expect_all_zero(input string tag);
        for (int k = 0; k <= O_BUS; k++) expect_val($sformatf("%s[%0d]", tag, k), k, 32'h0);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        drain();
        i       = '0;
        Read    = 1'b0;
        Mdatain = '0;
        ALU_Sel = '0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        i       = cw(5'd0, EN_MDR);
        Mdatain = v;
        Read    = 1'b1;
        expect_val("mdr_load", O_MDR, v);
        tick();
    endtask

    task automatic set_y(input logic [31:0] v);
        load_mdr(v);
        i = cw(5'd0, EN_Y);
        expect_val("y_load", O_Y, v);
        tick();
    endtask

    logic [4:0]  ops  [12] = '{5'd4, 5'd5, 5'd7, 5'd8, 5'd6, 5'd0, 5'd1, 5'd2, 5'd3, 5'd12, 5'd11, 5'd13};
    logic [31:0] zexp [12] = '{32'h40000000, 32'hC0000000, 32'hC0000000, 32'h00000003,
                               32'h00000002, 32'h80000002, 32'h80000000, 32'h80000001,
                               32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr = 1'b0; i = '0; ALU_Sel = '0; Mdatain = '0; Read = 1'b0;
        #2 clr = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        expect_all_zero("reset");
        drain();
        #3 clr = 1'b0;

        // Register loads through MDR
        load_mdr(32'h22);
        i = cw(5'd0, en_r(2));
        #1 expect_val("bus_mdr", O_BUS, 32'h22); drain();
        expect_val("r2", 2, 32'h22); tick();
        load_mdr(32'h24);
        i = cw(5'd0, en_r(4)); expect_val("r4", 4, 32'h24); tick();
        load_mdr(32'h26);
        i = cw(5'd0, en_r(5)); expect_val("r5", 5, 32'h26); tick();

        // Read without MDRin leaves MDR alone
        Read = 1'b1; Mdatain = 32'hDEAD;
        expect_val("read_only", O_MDR, 32'h26); tick();

        // AND sequence
        i = cw(5'd3, EN_Y); expect_val("and_y", O_Y, 32'h22); tick();
        i = cw(5'd5, EN_ZL); ALU_Sel = 5'd3;
        expect_val("and_zl", O_ZL, 32'h20); expect_val("and_zh", O_ZH, 32'h0); tick();
        i = cw(5'd20, en_r(5)); expect_val("and_r5", 5, 32'h20); tick();

        // Fetch
        i = cw(5'd21, EN_MAR | EN_INC);
        expect_val("fetch_mar", O_MAR, 32'h0); expect_val("fetch_pc", O_PC, 32'h1); tick();
        load_mdr(32'h4A920000);
        i = cw(5'd0, EN_IR); expect_val("fetch_ir", O_IR, 32'h4A920000); tick();

        // MUL
        set_y(32'h00010000);
        load_mdr(32'h00010000);
        i = cw(5'd0, EN_ZH | EN_ZL); ALU_Sel = 5'd9;
        expect_val("mul_zh", O_ZH, 32'h1); expect_val("mul_zl", O_ZL, 32'h0); tick();

        // DIV, then divide by zero
        set_y(32'hFFFFFFF9);
        load_mdr(32'h2);
        i = cw(5'd0, EN_ZH | EN_ZL); ALU_Sel = 5'd10;
        expect_val("div_q", O_ZL, 32'hFFFFFFFD); expect_val("div_r", O_ZH, 32'hFFFFFFFF); tick();
        load_mdr(32'h0);
        i = cw(5'd0, EN_ZH | EN_ZL); ALU_Sel = 5'd10;
        expect_val("div0_q", O_ZL, 32'hFFFFFFFF); expect_val("div0_r", O_ZH, 32'hFFFFFFF9); tick();

        // Shifts, rotates and single-word ops with Y=0x80000001, B=1
        set_y(32'h80000001);
        load_mdr(32'h1);
        for (int k = 0; k < 12; k++) begin
            i = cw(5'd0, EN_ZH | EN_ZL); ALU_Sel = ops[k];
            expect_val($sformatf("op%0d_zl", ops[k]), O_ZL, zexp[k]);
            expect_val($sformatf("op%0d_zh", ops[k]), O_ZH, 32'h0);
            tick();
        end

        // PC wrap and IncPC priority
        load_mdr(32'hFFFFFFFF);
        i = cw(5'd0, EN_PC); expect_val("pc_load", O_PC, 32'hFFFFFFFF); tick();
        i = cw(5'd0, EN_INC); expect_val("pc_wrap", O_PC, 32'h0); tick();
        i = cw(5'd0, EN_PC | EN_INC); expect_val("pc_prio", O_PC, 32'h1); tick();

        // Simultaneous loads, HI/LO bus sources, self-load, undefined bus code
        load_mdr(32'h12345678);
        i = cw(5'd0, EN_HI | en_r(0) | en_r(15));
        expect_val("multi_hi", O_HI, 32'h12345678); expect_val("multi_r0", 0, 32'h12345678);
        expect_val("multi_r15", 15, 32'h12345678); tick();
        load_mdr(32'h0BADF00D);
        i = cw(5'd0, EN_LO); expect_val("lo", O_LO, 32'h0BADF00D); tick();
        i = cw(5'd17, en_r(7));
        #1 expect_val("bus_hi", O_BUS, 32'h12345678); drain();
        expect_val("r7_from_hi", 7, 32'h12345678); tick();
        i = cw(5'd18, en_r(8)); expect_val("r8_from_lo", 8, 32'h0BADF00D); tick();
        i = cw(5'd16, en_r(15)); expect_val("self_r15", 15, 32'h12345678); tick();
        i = cw(5'd23, en_r(9));
        #1 expect_val("bus_code23", O_BUS, 32'h0); drain();
        tick();
        i = cw(5'd5, EN_MDR); expect_val("mdr_from_bus", O_MDR, 32'h24); tick();

        // Asynchronous reset while R5in is asserted
        i = cw(5'd0, en_r(5));
        #3 clr = 1'b1;
        #1 expect_all_zero("clr_async"); drain();
        @(posedge Clock);
        #1 expect_all_zero("clr_held"); drain();
        #3 clr = 1'b0;
        load_mdr(32'h55);
        i = cw(5'd0, en_r(5)); expect_val("post_reset_r5", 5, 32'h55); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
